// File: rtl/seg_display_pkg.sv
// rtl/seg_display_pkg.sv - seven-segment codes, decode helpers and scan state type
// All codes here are active-high; output polarity is applied at the output registers.
package seg_display_pkg;

  typedef logic [7:0] seg_code_t;

  localparam seg_code_t SEGNONE  = 8'h00;
  localparam seg_code_t SEG0     = 8'h3F;
  localparam seg_code_t SEG1     = 8'h06;
  localparam seg_code_t SEG2     = 8'h5B;
  localparam seg_code_t SEG3     = 8'h4F;
  localparam seg_code_t SEG4     = 8'h66;
  localparam seg_code_t SEG5     = 8'h6D;
  localparam seg_code_t SEG6     = 8'h7D;
  localparam seg_code_t SEG7     = 8'h07;
  localparam seg_code_t SEG8     = 8'h7F;
  localparam seg_code_t SEG9     = 8'h6F;
  localparam seg_code_t SEGA     = 8'h77;
  localparam seg_code_t SEGB     = 8'h7C;
  localparam seg_code_t SEGC     = 8'h39;
  localparam seg_code_t SEGD     = 8'h5E;
  localparam seg_code_t SEGE     = 8'h79;
  localparam seg_code_t SEGF     = 8'h71;
  localparam seg_code_t SEGERROR = 8'h49;

  typedef enum logic [1:0] {
    IDLE,
    GAP,
    SHOW
  } scan_state_e;

  function automatic seg_code_t hex_to_seg(input logic [3:0] nib);
    seg_code_t code;
    case (nib)
      4'h0:    code = SEG0;
      4'h1:    code = SEG1;
      4'h2:    code = SEG2;
      4'h3:    code = SEG3;
      4'h4:    code = SEG4;
      4'h5:    code = SEG5;
      4'h6:    code = SEG6;
      4'h7:    code = SEG7;
      4'h8:    code = SEG8;
      4'h9:    code = SEG9;
      4'hA:    code = SEGA;
      4'hB:    code = SEGB;
      4'hC:    code = SEGC;
      4'hD:    code = SEGD;
      4'hE:    code = SEGE;
      default: code = SEGF;
    endcase
    return code;
  endfunction

  // Error overrides blanking; the decimal point is always honoured.
  function automatic seg_code_t digit_code(input logic [3:0] nib, input logic blank,
                                           input logic err, input logic dp);
    seg_code_t code;
    if (err)
      code = SEGERROR;
    else if (blank)
      code = SEGNONE;
    else
      code = hex_to_seg(nib);
    return code | {dp, 7'b000_0000};
  endfunction

endpackage

// File: rtl/seg_display_ctrl_scan_fsm.sv
// rtl/seg_display_ctrl_scan_fsm.sv - seg_scan_fsm: time-multiplexed digit scanner
// Walks IDLE -> GAP -> SHOW per digit; segs_i is already at output polarity.
module seg_scan_fsm
  import seg_display_pkg::*;
#(
  parameter int NUM_DIGITS     = 8,
  parameter int SCAN_DIV_W     = 16,
  parameter int GAP_CYCLES     = 4,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit SEL_ACTIVE_LOW = 1'b1
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    mode_i,
  input  logic [NUM_DIGITS*8-1:0] segs_i,
  output logic [7:0]              scan_seg_o,
  output logic [NUM_DIGITS-1:0]   scan_sel_o
);

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);
  localparam seg_code_t SEG_OFF = SEG_ACTIVE_LOW ? ~SEGNONE : SEGNONE;

  scan_state_e             state, state_nxt;
  logic [IDX_W-1:0]        idx, idx_nxt;
  logic [GAP_W-1:0]        gap_cnt, gap_nxt;
  logic [SCAN_DIV_W-1:0]   dwell_cnt, dwell_nxt;
  logic [NUM_DIGITS-1:0]   sel_act;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state     <= IDLE;
      idx       <= '0;
      gap_cnt   <= '0;
      dwell_cnt <= '0;
    end else begin
      state     <= state_nxt;
      idx       <= idx_nxt;
      gap_cnt   <= gap_nxt;
      dwell_cnt <= dwell_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    gap_nxt   = '0;
    dwell_nxt = '0;
    if (!mode_i) begin
      state_nxt = IDLE;
      idx_nxt   = '0;
    end else begin
      case (state)
        IDLE: begin
          state_nxt = GAP;
          idx_nxt   = '0;
        end
        GAP: begin
          if (gap_cnt == GAP_LAST)
            state_nxt = SHOW;
          else
            gap_nxt = gap_cnt + GAP_W'(1);
        end
        SHOW: begin
          if (&dwell_cnt) begin
            state_nxt = GAP;
            idx_nxt   = (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);
          end else begin
            dwell_nxt = dwell_cnt + SCAN_DIV_W'(1);
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Select is decoded from registered state/idx, so it is at most one-hot.
  always_comb begin
    sel_act    = '0;
    scan_seg_o = SEG_OFF;
    if (state == SHOW) begin
      for (int k = 0; k < NUM_DIGITS; k++) begin
        if (idx == IDX_W'(k)) begin
          sel_act[k] = 1'b1;
          scan_seg_o = segs_i[8*k +: 8];
        end
      end
    end
    scan_sel_o = sel_act ^ {NUM_DIGITS{SEL_ACTIVE_LOW}};
  end

endmodule

// File: rtl/seg_display_ctrl.sv
// rtl/seg_display_ctrl.sv - seven-segment controller: refresh, decode, static and scan outputs
// Optional error_i input and SEGERROR load enabled by SEG_DISPLAY_ERROR_EN.
module seg_display_ctrl
  import seg_display_pkg::*;
#(
  parameter int NUM_DIGITS     = 8,
  parameter int REFRESH_DIV_W  = 26,
  parameter int SCAN_DIV_W     = 16,
  parameter int GAP_CYCLES     = 4,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit SEL_ACTIVE_LOW = 1'b1
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
`ifdef SEG_DISPLAY_ERROR_EN
  input  logic                    error_i,
`endif
  input  logic [4*NUM_DIGITS-1:0] value_i,
  input  logic [NUM_DIGITS-1:0]   dp_i,
  input  logic                    blank_lz_i,
  input  logic                    hold_i,
  input  logic                    mode_i,
  output logic [NUM_DIGITS*8-1:0] segs_o,
  output logic [7:0]              scan_seg_o,
  output logic [NUM_DIGITS-1:0]   scan_sel_o,
  output logic                    update_o
);

  localparam seg_code_t SEG_MASK = SEG_ACTIVE_LOW ? 8'hFF : 8'h00;

  logic [REFRESH_DIV_W-1:0] refresh_cnt;
  logic                     tick;
  logic                     err;
  logic                     leading;
  logic [NUM_DIGITS*8-1:0]  next_segs;

  assign tick = &refresh_cnt;

`ifdef SEG_DISPLAY_ERROR_EN
  assign err = error_i;
`else
  assign err = 1'b0;
`endif

  // Scan from the top digit down; blanking stops at the first non-zero nibble.
  always_comb begin
    next_segs = '0;
    leading   = blank_lz_i;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      if (value_i[4*k +: 4] != 4'h0 || k == 0)
        leading = 1'b0;
      next_segs[8*k +: 8] = digit_code(value_i[4*k +: 4], leading, err, dp_i[k]);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      refresh_cnt <= '0;
      segs_o      <= {NUM_DIGITS{SEGNONE ^ SEG_MASK}};
      update_o    <= 1'b0;
    end else begin
      refresh_cnt <= refresh_cnt + REFRESH_DIV_W'(1);
      update_o    <= 1'b0;
      if (tick && !hold_i) begin
        segs_o   <= next_segs ^ {NUM_DIGITS{SEG_MASK}};
        update_o <= 1'b1;
      end
    end
  end

  seg_scan_fsm #(
    .NUM_DIGITS     (NUM_DIGITS),
    .SCAN_DIV_W     (SCAN_DIV_W),
    .GAP_CYCLES     (GAP_CYCLES),
    .SEG_ACTIVE_LOW (SEG_ACTIVE_LOW),
    .SEL_ACTIVE_LOW (SEL_ACTIVE_LOW)
  ) u_scan (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .mode_i     (mode_i),
    .segs_i     (segs_o),
    .scan_seg_o (scan_seg_o),
    .scan_sel_o (scan_sel_o)
  );

endmodule

// File: tb/tb_seg_display_ctrl.sv
// tb/tb_seg_display_ctrl.sv - self-checking bench for seg_display_ctrl
// Four digits, 8-cycle refresh, 4-cycle dwell, 4-cycle gap, active-low outputs.
module tb_seg_display_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] value = '0;
  logic [3:0]  dp = '0;
  logic        blank = 1'b0;
  logic        hold = 1'b0;
  logic        mode = 1'b0;
  logic [31:0] segs;
  logic [7:0]  scan_seg;
  logic [3:0]  scan_sel;
  logic        update;
`ifdef SEG_DISPLAY_ERROR_EN
  logic        error_in = 1'b0;
`endif

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  seg_display_ctrl #(
    .NUM_DIGITS     (4),
    .REFRESH_DIV_W  (3),
    .SCAN_DIV_W     (2),
    .GAP_CYCLES     (4),
    .SEG_ACTIVE_LOW (1'b1),
    .SEL_ACTIVE_LOW (1'b1)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst),
`ifdef SEG_DISPLAY_ERROR_EN
    .error_i    (error_in),
`endif
    .value_i    (value),
    .dp_i       (dp),
    .blank_lz_i (blank),
    .hold_i     (hold),
    .mode_i     (mode),
    .segs_o     (segs),
    .scan_seg_o (scan_seg),
    .scan_sel_o (scan_sel),
    .update_o   (update)
  );

  typedef struct {
    logic [15:0] value;
    logic [3:0]  dp;
    logic        blank;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic wait_update(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (update !== 1'b1 && n < 24);
    check("update_seen", 32'(update), 32'd1);
  endtask

  initial begin
    int          n;
    int          upd_cnt;
    int          phase;
    int          dig;
    logic [3:0]  one;
    logic [3:0]  exp_sel;
    logic [7:0]  exp_seg;
    logic [31:0] frozen;

    vecs[0] = '{16'h1A3F, 4'b0000, 1'b0, ~32'h06774F71};
    vecs[1] = '{16'h0050, 4'b1000, 1'b1, ~32'h80006D3F};
    vecs[2] = '{16'h0000, 4'b0000, 1'b1, ~32'h0000003F};
    vecs[3] = '{16'h0000, 4'b0000, 1'b0, ~32'h3F3F3F3F};
    vecs[4] = '{16'h89BC, 4'b0101, 1'b0, ~32'h7FEF7CB9};
    vecs[5] = '{16'h0207, 4'b0000, 1'b1, ~32'h005B3F07};
    vecs[6] = '{16'h0D00, 4'b0001, 1'b1, ~32'h005E3FBF};
    vecs[7] = '{16'h4E62, 4'b0000, 1'b1, ~32'h66797D5B};

    // Reset state and first-tick latency.
    @(negedge clk);
    check("rst_segs", segs, 32'hFFFF_FFFF);
    check("rst_sel", 32'(scan_sel), 32'hF);
    check("rst_scan_seg", 32'(scan_seg), 32'hFF);
    check("rst_update", 32'(update), 32'd0);
    rst = 1'b0;
    wait_update(n);
    check("first_update_latency", 32'(n), 32'd8);

    for (int i = 0; i < 8; i++) begin
      value = vecs[i].value;
      dp    = vecs[i].dp;
      blank = vecs[i].blank;
      wait_update(n);
      check($sformatf("decode_%0d", i), segs, vecs[i].exp);
      @(negedge clk);
      check($sformatf("update_width_%0d", i), 32'(update), 32'd0);
    end

    // Hold across two ticks with a changed value.
    hold    = 1'b1;
    value   = 16'hFFFF;
    blank   = 1'b0;
    dp      = 4'b0000;
    upd_cnt = 0;
    repeat (18) begin
      @(negedge clk);
      if (update === 1'b1) upd_cnt++;
    end
    check("hold_no_update", 32'(upd_cnt), 32'd0);
    check("hold_segs", segs, vecs[7].exp);
    value = 16'h1A3F;
    hold  = 1'b0;
    wait_update(n);
    check("hold_release_latency", 32'(n <= 8), 32'd1);
    frozen = ~32'h06774F71;
    check("hold_release_segs", segs, frozen);

    // Scan sequence with segs frozen.
    hold = 1'b1;
    mode = 1'b1;
    for (int c = 0; c < 38; c++) begin
      @(negedge clk);
      phase = c % 8;
      dig   = (c / 8) % 4;
      one   = 4'b0001 << dig;
      if (phase < 4) begin
        exp_sel = 4'hF;
        exp_seg = 8'hFF;
      end else begin
        exp_sel = ~one;
        exp_seg = frozen[8*dig +: 8];
      end
      check($sformatf("scan_sel_%0d", c), 32'(scan_sel), 32'(exp_sel));
      check($sformatf("scan_seg_%0d", c), 32'(scan_seg), 32'(exp_seg));
      check($sformatf("scan_onehot_%0d", c), 32'($countones(~scan_sel) <= 1), 32'd1);
    end
    mode = 1'b0;
    @(negedge clk);
    check("mode_off_sel", 32'(scan_sel), 32'hF);
    check("mode_off_seg", 32'(scan_seg), 32'hFF);

    // Asynchronous reset in the middle of SHOW.
    mode = 1'b1;
    repeat (7) @(negedge clk);
    check("pre_reset_show", 32'(scan_sel), 32'hE);
    #2 rst = 1'b1;
    #1;
    check("async_rst_segs", segs, 32'hFFFF_FFFF);
    check("async_rst_sel", 32'(scan_sel), 32'hF);
    check("async_rst_scan_seg", 32'(scan_seg), 32'hFF);
    check("async_rst_update", 32'(update), 32'd0);
    mode = 1'b0;
    hold = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    wait_update(n);
    check("post_reset_latency", 32'(n), 32'd8);
    check("post_reset_segs", segs, frozen);

`ifdef SEG_DISPLAY_ERROR_EN
    error_in = 1'b1;
    value    = 16'h0000;
    blank    = 1'b1;
    dp       = 4'b0010;
    wait_update(n);
    check("error_segs", segs, ~32'h4949C949);
    error_in = 1'b0;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
